// File: rtl/ins_reg_pkg.sv
// Shared field widths and opcode encoding for the 8-bit RISC CPU.
// Imported by the instruction register, controller and ALU.
package ins_reg_pkg;

    localparam int DATA_W   = 8;
    localparam int OPCODE_W = 3;
    localparam int ADDR_W   = DATA_W - OPCODE_W;
    localparam int NUM_OPS  = 2 ** OPCODE_W;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    // Decode seen while ir is cleared: reset opcode is HLT.
    localparam logic [NUM_OPS-1:0] HLT_ONEHOT = NUM_OPS'(1);

endpackage

// File: rtl/ins_reg_decode.sv
// Combinational opcode decode for the instruction register.
// Only built when INS_REG_DECODE_EN is defined.
`ifdef INS_REG_DECODE_EN
module ins_reg_decode
    import ins_reg_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [NUM_OPS-1:0]  op_onehot,
    output logic                is_halt,
    output logic                is_mem_ref
);

    always_comb begin
        op_onehot         = '0;
        op_onehot[opcode] = 1'b1;
        is_halt           = 1'b0;
        is_mem_ref        = 1'b0;
        unique case (opcode_e'(opcode))
            OP_HLT:                 is_halt    = 1'b1;
            OP_LDA, OP_STO, OP_JMP: is_mem_ref = 1'b1;
            default: ;
        endcase
    end

endmodule
`endif

// File: rtl/ins_reg.sv
// Instruction register: holds one word, splits it into opcode/address.
// Optional decode outputs are enabled by INS_REG_DECODE_EN.
module ins_reg
    import ins_reg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_ir,
    input  logic [DATA_W-1:0]   data_in,
`ifdef INS_REG_DECODE_EN
    output logic [NUM_OPS-1:0]  op_onehot,
    output logic                is_halt,
    output logic                is_mem_ref,
`endif
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   ir_addr
);

    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;

    // An unknown strobe falls to the hold branch.
    always_comb begin
        ir_d = ir_q;
        if (ld_ir == 1'b1) begin
            ir_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign opcode  = ir_q[DATA_W-1:ADDR_W];
    assign ir_addr = ir_q[ADDR_W-1:0];

`ifdef INS_REG_DECODE_EN
    ins_reg_decode u_decode (
        .opcode     (opcode),
        .op_onehot  (op_onehot),
        .is_halt    (is_halt),
        .is_mem_ref (is_mem_ref)
    );
`endif

endmodule

// File: tb/tb_ins_reg.sv
// Self-checking bench for ins_reg: vector table, scoreboard queue,
// and hand-written reset sequences.
module tb_ins_reg;
    import ins_reg_pkg::*;

    logic                clk;
    logic                rst;
    logic                ld_ir;
    logic [DATA_W-1:0]   data_in;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   ir_addr;
`ifdef INS_REG_DECODE_EN
    logic [NUM_OPS-1:0]  op_onehot;
    logic                is_halt;
    logic                is_mem_ref;
`endif

    ins_reg dut (
        .clk        (clk),
        .rst        (rst),
        .ld_ir      (ld_ir),
        .data_in    (data_in),
`ifdef INS_REG_DECODE_EN
        .op_onehot  (op_onehot),
        .is_halt    (is_halt),
        .is_mem_ref (is_mem_ref),
`endif
        .opcode     (opcode),
        .ir_addr    (ir_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] addr;
    } exp_t;

    typedef struct {
        logic       ld;
        logic [7:0] data;
        exp_t       exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input exp_t e);
        check({name, ".opcode"}, 8'(opcode), 8'(e.op));
        check({name, ".ir_addr"}, 8'(ir_addr), 8'(e.addr));
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got %0d expected 1 entry",
                     name, sbq.size());
        end else begin
            e = sbq.pop_front();
            check_out(name, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
        $fatal(1, "timeout");
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 8'hBF, '{3'b101, 5'b11111}};
        vecs[1] = '{1'b0, 8'h00, '{3'b101, 5'b11111}};
        vecs[2] = '{1'b0, 8'h00, '{3'b101, 5'b11111}};
        vecs[3] = '{1'b1, 8'h21, '{3'b001, 5'b00001}};
        vecs[4] = '{1'b1, 8'hC5, '{3'b110, 5'b00101}};
        vecs[5] = '{1'bx, 8'h7A, '{3'b110, 5'b00101}};
        vecs[6] = '{1'b1, 8'h7A, '{3'b011, 5'b11010}};
        vecs[7] = '{1'b1, 8'h00, '{3'b000, 5'b00000}};
        vecs[8] = '{1'b1, 8'hFF, '{3'b111, 5'b11111}};

        rst     = 1'b0;
        ld_ir   = 1'b0;
        data_in = 8'h54;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_out("rst_async", '{3'b000, 5'b00000});
`ifdef INS_REG_DECODE_EN
        check("rst_onehot", op_onehot, HLT_ONEHOT);
        check("rst_is_halt", 8'(is_halt), 8'd1);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_out("rst_release", '{3'b000, 5'b00000});

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ld_ir   = vecs[i].ld;
            data_in = vecs[i].data;
            sbq.push_back(vecs[i].exp);
            @(posedge clk);
            #1 pop_check($sformatf("vec%0d", i));
`ifdef INS_REG_DECODE_EN
            check($sformatf("vec%0d.is_halt", i), 8'(is_halt),
                  8'(vecs[i].exp.op == 3'b000));
            check($sformatf("vec%0d.is_mem_ref", i), 8'(is_mem_ref),
                  8'(vecs[i].exp.op >= 3'b101));
            if (i == 0) begin
                check("bf_onehot", op_onehot, 8'h20);
            end
`endif
        end

        // Reset arriving mid load cycle wins over ld_ir.
        @(negedge clk);
        data_in = 8'hE3;
        ld_ir   = 1'b1;
        rst     = 1'b1;
        #1 check_out("rst_mid_load", '{3'b000, 5'b00000});
        @(posedge clk);
        #1 check_out("rst_over_edge", '{3'b000, 5'b00000});
        @(negedge clk);
        rst = 1'b0;
        sbq.push_back('{3'b111, 5'b00011});
        @(posedge clk);
        #1 pop_check("post_rst_load");

        // Back-to-back loads over consecutive edges.
        @(negedge clk);
        data_in = 8'h21;
        sbq.push_back('{3'b001, 5'b00001});
        @(posedge clk);
        #1 pop_check("b2b_first");
        data_in = 8'hC5;
        sbq.push_back('{3'b110, 5'b00101});
        @(posedge clk);
        #1 pop_check("b2b_second");

        // Hold ignores data_in changes.
        ld_ir   = 1'b0;
        data_in = 8'h3C;
        @(posedge clk);
        #1 check_out("hold_final", '{3'b110, 5'b00101});

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sbq.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ins_reg.md
Name: ins_reg

Overview:
- Instruction register for the simple 8-bit RISC CPU.
- Captures one 8-bit instruction word from the memory data bus when the controller asserts the load strobe.
- Splits the held word into a 3-bit opcode field for the controller/ALU and a 5-bit operand address field for the address mux.
- Sits between the memory data bus and the controller/address path; holds the word until the next load or reset.

Parameters:
- DATA_W, 8, instruction word width.
- OPCODE_W, 3, opcode field width; taken from the MSBs of the word.
- ADDR_W, DATA_W-OPCODE_W (5), operand address field width; taken from the LSBs of the word.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- ld_ir  input  1  load strobe; word is captured on a rising clk edge while high.
- data_in  input  DATA_W  instruction word from the memory data bus.
- opcode  output  OPCODE_W  held word bits [DATA_W-1 : ADDR_W].
- ir_addr  output  ADDR_W  held word bits [ADDR_W-1 : 0].

Behaviour:
- State: one DATA_W-bit register ir. Outputs are continuous slices of ir: opcode = ir[7:5], ir_addr = ir[4:0]. No combinational path from data_in to the outputs.
- Reset: rst high clears ir to 0 immediately, without waiting for a clock edge. While rst is high, opcode = 3'b000 and ir_addr = 5'b00000, regardless of clk, ld_ir or data_in.
- Load: on a rising clk edge with rst low and ld_ir high, ir <= data_in. New values are visible on the outputs right after that edge (latency 1 edge).
- Hold: on a rising clk edge with ld_ir low, ir keeps its value. Changes on data_in are ignored.
- Simultaneous events: rst overrides ld_ir. An assertion of rst in the middle of a load cycle clears ir at once, and no load happens on any edge while rst is high.
- After rst is released, the first rising edge with ld_ir high loads normally.
- Back-to-back loads: ld_ir held high over N edges captures data_in at each of those edges.
- Unknown ld_ir: treat as no-load. The block performs no other validity checking.
- Opcode encoding (interpretation only, used by the optional decode): 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.

Optional Feature:
- Macro: INS_REG_DECODE_EN.
- When defined, the block adds these outputs:
  - op_onehot (2**OPCODE_W bits): one-hot decode of opcode; bit k is high when opcode == k. Resets to 8'b0000_0001 because the reset opcode is HLT.
  - is_halt (1 bit): high when opcode == HLT.
  - is_mem_ref (1 bit): high for LDA, STO or JMP.
- All three outputs are combinational decodes of the registered ir, so they add no extra latency.
- When not defined, these ports and their logic are absent. Base behaviour is identical in both builds.

Decomposition:
- Package ins_reg_pkg holds:
  - DATA_W, OPCODE_W, ADDR_W localparams;
  - an opcode_e enum type (3 bits) with the eight mnemonics above;
  - the HLT reset-decode constant.
- The controller and ALU import the same package.
- The base block needs no sub-module. Under INS_REG_DECODE_EN, one sub-module ins_reg_decode (opcode in; op_onehot, is_halt, is_mem_ref out) is natural.

Test Plan:
- Assert rst with data_in=0x54 and ld_ir=0 -> opcode=000 and ir_addr=00000 immediately, without a clock edge; both stay zero after rst drops.
- ld_ir=1, data_in=0xBF, one rising edge -> opcode=101 and ir_addr=11111 right after the edge.
- ld_ir=0, data_in=0x00, two edges -> outputs stay 101/11111.
- data_in=0xE3, ld_ir=1, rst asserted 5 ns before the next edge and held for 10 ns -> outputs go 000/00000 at once and stay zero through the edge. After rst=0 with ld_ir=1, the next edge gives 111/00011.
- Back-to-back loads of 0x21 then 0xC5 on consecutive edges -> 001/00001, then 110/00101.
- With INS_REG_DECODE_EN: after reset op_onehot=0x01 and is_halt=1. Loading 0xBF gives op_onehot=0x20, is_mem_ref=1, is_halt=0.
